ntt_mem_arbiter: RTL and testbench
==================================

Name: ntt_mem_arbiter

Overview:
- Shares one downstream memory port among NUM_PORTS ntt_core memory ports: round-robin, non-skipping arbitration.
- Registered single-entry issue stage toward memory; in-order read-response routing through a tag FIFO.
- Sits between the ntt_core array and the host-memory/DMA bridge. Provides a sticky protocol-error flag and a debug grant counter.

Parameters:
- NUM_PORTS, 4, number of requesting cores (≥2).
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MAX_OUTST, 4, maximum reads issued but not yet answered; also the tag FIFO depth.
- Derived: IDX_W = clog2(NUM_PORTS); CNT_W = clog2(MAX_OUTST+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- p_req  in  NUM_PORTS  per-core request; held with we/addr/wdata until that core's gnt
- p_we  in  NUM_PORTS  per-core write enable
- p_addr  in  NUM_PORTS*ADDR_W  flattened, port i at [i*ADDR_W +: ADDR_W]
- p_wdata  in  NUM_PORTS*DATA_W  flattened
- p_gnt  out  NUM_PORTS  one-cycle acceptance pulse
- p_valid  out  NUM_PORTS  one-cycle read-data pulse
- p_rdata  out  DATA_W  shared read-data bus, meaningful with any p_valid
- dn_req  out  1  downstream request
- dn_we  out  1  downstream write enable
- dn_addr  out  ADDR_W  downstream address
- dn_wdata  out  DATA_W  downstream write data
- dn_ack  in  1  downstream accepts the request in this cycle
- dn_rvalid  in  1  downstream read data valid; returned in issue order
- dn_rdata  in  DATA_W  downstream read data
- outst  out  CNT_W  reads currently outstanding
- err  out  1  sticky: dn_rvalid received with tag FIFO empty
- grant_count  out  64  total grants since reset

Behaviour:
- Reset (synchronous): p_gnt, p_valid, dn_req, dn_we, err, outst, grant_count and RR pointer = 0; p_rdata, dn_addr, dn_wdata = 0; issue register and tag FIFO empty.
- Eligibility: port i is eligible when p_req[i]=1 and p_gnt[i]=0 in the current cycle. Masking the just-granted port prevents double issue, since its req is still high that cycle.
- Winner: first eligible port scanning i = ptr, ptr+1, … mod NUM_PORTS.
- Capture allowed when both hold:
  - the issue register is empty, or dn_req&&dn_ack this cycle;
  - the winner is a write, or outst < MAX_OUTST.
- On capture at an edge:
  - the issue register loads the winner's we/addr/wdata and its index; dn_req=1 next cycle;
  - p_gnt[winner]=1 for exactly that next cycle;
  - ptr = winner+1 mod NUM_PORTS;
  - grant_count +1, wrapping;
  - if the winner is a read, outst +1.
- Non-skipping: if the winner is a read blocked by outst==MAX_OUTST, nothing is captured that cycle, even when a lower-priority write is pending.
- Grant-to-memory latency: 1 cycle from req seen to dn_req. Issue register holds dn_* stable while dn_ack=0. Back-to-back capture is allowed on the acking cycle.
- Tag FIFO push: on dn_req&&dn_ack&&!dn_we, push the issue-register index. Depth MAX_OUTST; cannot overflow because of the outst reservation.
- Tag FIFO pop: on dn_rvalid with FIFO non-empty, pop tag t. Next cycle p_valid[t]=1 and p_rdata=dn_rdata (registered, 1-cycle latency). outst −1 in the same edge as the pop.
- Capture and pop in the same cycle: outst net unchanged.
- dn_rvalid with FIFO empty: data dropped, err=1 until reset, outst unchanged.
- Push and pop in the same cycle: legal; FIFO count unchanged.
- Writes have no response. p_gnt is the completion signal from the core's point of view.
- Reset mid-operation: in-flight reads are discarded. Memory must be reset together with the arbiter, otherwise late dn_rvalid sets err.

Decomposition:
- Package ntt_mem_pkg: ADDR_W/DATA_W defaults, IDX_W/CNT_W helper functions, request struct {we, addr, wdata, idx}.
- One natural sub-module: ntt_tag_fifo, a synchronous FIFO of IDX_W-bit tags with push/pop/empty/count, depth MAX_OUTST.
- RR pick and the issue register stay in the top.

Test Plan:
- Port 0 reads addr 0x100 with dn_ack=1 and memory returning 0xDEAD 2 cycles later:
  - p_gnt[0] one cycle after req;
  - p_valid[0] with p_rdata=0xDEAD one cycle after dn_rvalid;
  - outst goes 0→1→0.
- Ports 0–3 all hold req from reset (dn_ack=1): grants in order 0,1,2,3,0; no port granted twice on consecutive cycles while still requesting; grant_count=5 after five grants.
- Port 1 write 0x55 to 0x20 with dn_ack held low 3 cycles: dn_req/dn_addr/dn_wdata stable across the stall; no second capture until the ack cycle; p_valid stays 0.
- MAX_OUTST=4 reads issued with no responses, then port 2 read and port 3 write pending:
  - no capture while outst=4, write included (non-skipping);
  - after one dn_rvalid, port 2 is granted first.
- Reads from ports 3 then 1, responses 0xA then 0xB: p_valid[3] carries 0xA, then p_valid[1] carries 0xB.
- dn_rvalid with nothing outstanding: err=1 and remains 1; no p_valid; outst stays 0; rst clears err.

Source files
------------

// File: rtl/ntt_mem_pkg.sv
// Shared definitions for the ntt_core memory arbiter slice: default widths,
// derived-width helpers and the fixed-width request record.
package ntt_mem_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_IDX_W  = 2;

    // Width of a port index; a single bit is kept even for two ports
    function automatic int idx_w(input int numPorts);
        return (numPorts <= 2) ? 1 : $clog2(numPorts);
    endfunction

    // Width of a counter that has to reach maxCount inclusive
    function automatic int cnt_w(input int maxCount);
        return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
    endfunction

    // Request record at the default widths, for code that needs a fixed type
    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        logic [DEF_IDX_W-1:0]  idx;
    } mem_req_t;

endpackage

// File: rtl/ntt_tag_fifo.sv
// Synchronous FIFO of requester tags, one entry per read accepted downstream.
// Entries leave in the same order memory returns read data.
module ntt_tag_fifo
    import ntt_mem_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int TAG_W = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = cnt_w(DEPTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [TAG_W-1:0] i_pushTag,
    input  logic             i_pop,
    output logic [TAG_W-1:0] o_popTag,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_doPop;
    logic w_doPush;

    // Ignore pops on empty; a push on full is only taken if a pop frees a slot
    always_comb begin
        w_empty  = (r_count == '0);
        w_full   = (r_count == CNT_W'(DEPTH));
        w_doPop  = i_pop && !w_empty;
        w_doPush = i_push && (!w_full || w_doPop);
    end

    // Tag storage needs no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushTag;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_popTag = r_mem[r_rdPtr];
    assign o_empty  = w_empty;
    assign o_count  = r_count;

endmodule

// File: rtl/ntt_mem_arbiter.sv
// Shares one downstream memory port among NUM_PORTS ntt_core ports.
// Round-robin, non-skipping pick into a single registered issue slot; read
// responses are routed back in issue order through a tag FIFO.
module ntt_mem_arbiter
    import ntt_mem_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int MAX_OUTST = 4,
    localparam int IDX_W     = idx_w(NUM_PORTS),
    localparam int CNT_W     = cnt_w(MAX_OUTST)
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        p_req,
    input  logic [NUM_PORTS-1:0]        p_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
    output logic [NUM_PORTS-1:0]        p_gnt,
    output logic [NUM_PORTS-1:0]        p_valid,
    output logic [DATA_W-1:0]           p_rdata,
    output logic                        dn_req,
    output logic                        dn_we,
    output logic [ADDR_W-1:0]           dn_addr,
    output logic [DATA_W-1:0]           dn_wdata,
    input  logic                        dn_ack,
    input  logic                        dn_rvalid,
    input  logic [DATA_W-1:0]           dn_rdata,
    output logic [CNT_W-1:0]            outst,
    output logic                        err,
    output logic [63:0]                 grant_count
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [IDX_W-1:0]  idx;
    } issue_t;

    issue_t               r_issue;
    logic                 r_issueValid;
    logic [NUM_PORTS-1:0] r_gnt;
    logic [NUM_PORTS-1:0] r_valid;
    logic [DATA_W-1:0]    r_rdata;
    logic [IDX_W-1:0]     r_ptr;
    logic [CNT_W-1:0]     r_outst;
    logic                 r_err;
    logic [63:0]          r_grantCount;

    logic [NUM_PORTS-1:0] w_elig;
    logic                 w_found;
    logic [IDX_W-1:0]     w_winIdx;
    logic [IDX_W-1:0]     w_cand;
    logic                 w_winWe;
    logic [ADDR_W-1:0]    w_winAddr;
    logic [DATA_W-1:0]    w_winWdata;
    logic [NUM_PORTS-1:0] w_winOneHot;
    logic                 w_accept;
    logic                 w_slotFree;
    logic                 w_capture;
    logic                 w_incr;

    logic                 w_tagEmpty;
    logic [CNT_W-1:0]     w_tagCount;
    logic [IDX_W-1:0]     w_popTag;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_orphan;

    // Mask the port granted last cycle: its request is still up while it sees the grant
    assign w_elig = p_req & ~r_gnt;

    // First eligible port scanning upward from the round-robin pointer
    always_comb begin
        w_found  = 1'b0;
        w_winIdx = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % NUM_PORTS);
            if (!w_found && w_elig[w_cand]) begin
                w_found  = 1'b1;
                w_winIdx = w_cand;
            end
        end
    end

    // Capture needs a free slot and, for reads, an unreserved response slot;
    // a blocked read winner stalls everyone so a later write cannot overtake it
    always_comb begin
        w_winWe     = p_we[w_winIdx];
        w_winAddr   = p_addr[int'(w_winIdx) * ADDR_W +: ADDR_W];
        w_winWdata  = p_wdata[int'(w_winIdx) * DATA_W +: DATA_W];
        w_winOneHot = NUM_PORTS'(1) << w_winIdx;
        w_accept    = r_issueValid && dn_ack;
        w_slotFree  = !r_issueValid || dn_ack;
        w_capture   = w_found && w_slotFree &&
                      (w_winWe || (r_outst < CNT_W'(MAX_OUTST)));
        w_incr      = w_capture && !w_winWe;
        w_push      = w_accept && !r_issue.we;
        w_pop       = dn_rvalid && (w_tagCount != '0);
        w_orphan    = dn_rvalid && w_tagEmpty;
    end

    ntt_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .TAG_W (IDX_W)
    ) u_tagFifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pushTag (r_issue.idx),
        .i_pop     (w_pop),
        .o_popTag  (w_popTag),
        .o_empty   (w_tagEmpty),
        .o_count   (w_tagCount)
    );

    // Issue register: load on capture, drain on ack, otherwise hold dn_* stable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issueValid <= 1'b0;
            r_issue      <= '0;
        end else if (w_capture) begin
            r_issueValid <= 1'b1;
            r_issue      <= '{we: w_winWe, addr: w_winAddr, wdata: w_winWdata, idx: w_winIdx};
        end else if (w_accept) begin
            r_issueValid <= 1'b0;
        end
    end

    // Grant pulse, pointer advance and debug grant count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt        <= '0;
            r_ptr        <= '0;
            r_grantCount <= '0;
        end else if (w_capture) begin
            r_gnt        <= w_winOneHot;
            r_ptr        <= (w_winIdx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_winIdx + IDX_W'(1);
            r_grantCount <= r_grantCount + 64'd1;
        end else begin
            r_gnt        <= '0;
        end
    end

    // Outstanding-read reservation: counted at capture, released at response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outst <= '0;
        end else begin
            case ({w_incr, w_pop})
                2'b10:   r_outst <= r_outst + CNT_W'(1);
                2'b01:   r_outst <= r_outst - CNT_W'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Route read data to the oldest outstanding requester; orphan data sets the sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_pop ? (NUM_PORTS'(1) << w_popTag) : '0;
            if (w_pop) begin
                r_rdata <= dn_rdata;
            end
            if (w_orphan) begin
                r_err <= 1'b1;
            end
        end
    end

    assign p_gnt       = r_gnt;
    assign p_valid     = r_valid;
    assign p_rdata     = r_rdata;
    assign dn_req      = r_issueValid;
    assign dn_we       = r_issue.we;
    assign dn_addr     = r_issue.addr;
    assign dn_wdata    = r_issue.wdata;
    assign outst       = r_outst;
    assign err         = r_err;
    assign grant_count = r_grantCount;

endmodule

// File: tb/tb_ntt_mem_arbiter.sv
// Directed bench for ntt_mem_arbiter with hand-computed expectations.
module tb_ntt_mem_arbiter;

    localparam int NP = 4;
    localparam int AW = 64;
    localparam int DW = 64;

    logic           clk;
    logic           rst;
    logic [NP-1:0]  p_req;
    logic [NP-1:0]  p_we;
    logic [NP*AW-1:0] p_addr;
    logic [NP*DW-1:0] p_wdata;
    logic [NP-1:0]  p_gnt;
    logic [NP-1:0]  p_valid;
    logic [DW-1:0]  p_rdata;
    logic           dn_req;
    logic           dn_we;
    logic [AW-1:0]  dn_addr;
    logic [DW-1:0]  dn_wdata;
    logic           dn_ack;
    logic           dn_rvalid;
    logic [DW-1:0]  dn_rdata;
    logic [2:0]     outst;
    logic           err;
    logic [63:0]    grant_count;

    int testCount = 0;
    int failCount = 0;

    ntt_mem_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_OUTST (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p_req       (p_req),
        .p_we        (p_we),
        .p_addr      (p_addr),
        .p_wdata     (p_wdata),
        .p_gnt       (p_gnt),
        .p_valid     (p_valid),
        .p_rdata     (p_rdata),
        .dn_req      (dn_req),
        .dn_we       (dn_we),
        .dn_addr     (dn_addr),
        .dn_wdata    (dn_wdata),
        .dn_ack      (dn_ack),
        .dn_rvalid   (dn_rvalid),
        .dn_rdata    (dn_rdata),
        .outst       (outst),
        .err         (err),
        .grant_count (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one core's request lines
    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [63:0] addr, input logic [63:0] wdata);
        p_req[port]             = req;
        p_we[port]              = we;
        p_addr[port*AW +: AW]   = addr;
        p_wdata[port*DW +: DW]  = wdata;
    endtask

    // Count one comparison and report it when it disagrees
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    logic [3:0]  expTag [4];
    logic [63:0] expData;

    initial begin
        rst       = 1'b1;
        p_req     = '0;
        p_we      = '0;
        p_addr    = '0;
        p_wdata   = '0;
        dn_ack    = 1'b0;
        dn_rvalid = 1'b0;
        dn_rdata  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_gnt",   64'(p_gnt), 64'h0);
        checkOutput("rst_valid", 64'(p_valid), 64'h0);
        checkOutput("rst_dnreq", 64'(dn_req), 64'h0);
        checkOutput("rst_outst", 64'(outst), 64'h0);
        checkOutput("rst_err",   64'(err), 64'h0);
        checkOutput("rst_gcnt",  grant_count, 64'h0);

        // Single read from port 0
        $display("[TB] single read");
        dn_ack = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 64'h100, 64'h0);
        tick();
        checkOutput("rd_gnt",   64'(p_gnt), 64'h1);
        checkOutput("rd_dnreq", 64'(dn_req), 64'h1);
        checkOutput("rd_addr",  dn_addr, 64'h100);
        checkOutput("rd_we",    64'(dn_we), 64'h0);
        checkOutput("rd_outst1", 64'(outst), 64'h1);
        applyStimulus(0, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        checkOutput("rd_dnreq_off", 64'(dn_req), 64'h0);
        checkOutput("rd_gnt_off",   64'(p_gnt), 64'h0);
        tick();
        checkOutput("rd_outst_wait", 64'(outst), 64'h1);
        dn_rvalid = 1'b1;
        dn_rdata  = 64'hDEAD;
        tick();
        dn_rvalid = 1'b0;
        checkOutput("rd_valid", 64'(p_valid), 64'h1);
        checkOutput("rd_data",  p_rdata, 64'hDEAD);
        checkOutput("rd_outst0", 64'(outst), 64'h0);
        tick();
        checkOutput("rd_valid_off", 64'(p_valid), 64'h0);

        // Four ports requesting from reset: round-robin 0,1,2,3,0
        $display("[TB] round robin");
        rst = 1'b1;
        for (int i = 0; i < NP; i++) begin
            applyStimulus(i, 1'b1, 1'b1, 64'h1000 + 64'(i), 64'h0);
        end
        tick();
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            checkOutput($sformatf("rr_gnt%0d", n), 64'(p_gnt), 64'(4'b1 << (n % 4)));
            checkOutput($sformatf("rr_addr%0d", n), dn_addr, 64'h1000 + 64'(n % 4));
        end
        checkOutput("rr_gcnt", grant_count, 64'd5);
        for (int i = 0; i < NP; i++) begin
            applyStimulus(i, 1'b0, 1'b0, 64'h0, 64'h0);
        end
        tick();
        checkOutput("rr_drain", 64'(dn_req), 64'h0);

        // Write from port 1 stalled by dn_ack low; port 2 waits behind it
        $display("[TB] stalled write");
        dn_ack = 1'b0;
        applyStimulus(1, 1'b1, 1'b1, 64'h20, 64'h55);
        tick();
        checkOutput("wr_gnt",   64'(p_gnt), 64'h2);
        checkOutput("wr_dnreq", 64'(dn_req), 64'h1);
        checkOutput("wr_we",    64'(dn_we), 64'h1);
        applyStimulus(1, 1'b0, 1'b0, 64'h0, 64'h0);
        applyStimulus(2, 1'b1, 1'b1, 64'h30, 64'h66);
        for (int s = 0; s < 3; s++) begin
            tick();
            checkOutput($sformatf("st_req%0d", s),   64'(dn_req), 64'h1);
            checkOutput($sformatf("st_addr%0d", s),  dn_addr, 64'h20);
            checkOutput($sformatf("st_wdata%0d", s), dn_wdata, 64'h55);
            checkOutput($sformatf("st_gnt%0d", s),   64'(p_gnt), 64'h0);
            checkOutput($sformatf("st_valid%0d", s), 64'(p_valid), 64'h0);
        end
        dn_ack = 1'b1;
        tick();
        checkOutput("b2b_gnt",   64'(p_gnt), 64'h4);
        checkOutput("b2b_addr",  dn_addr, 64'h30);
        checkOutput("b2b_wdata", dn_wdata, 64'h66);
        applyStimulus(2, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        checkOutput("b2b_idle", 64'(dn_req), 64'h0);
        checkOutput("wr_outst", 64'(outst), 64'h0);

        // Fill the read budget, then a read and a write wait behind it
        $display("[TB] outstanding limit");
        applyStimulus(0, 1'b1, 1'b0, 64'h400, 64'h0);
        applyStimulus(1, 1'b1, 1'b0, 64'h410, 64'h0);
        for (int n = 0; n < 4; n++) begin
            tick();
            checkOutput($sformatf("lim_gnt%0d", n), 64'(p_gnt), (n % 2 == 0) ? 64'h1 : 64'h2);
        end
        checkOutput("lim_outst4", 64'(outst), 64'h4);
        applyStimulus(0, 1'b0, 1'b0, 64'h0, 64'h0);
        applyStimulus(1, 1'b0, 1'b0, 64'h0, 64'h0);
        applyStimulus(2, 1'b1, 1'b0, 64'h420, 64'h0);
        applyStimulus(3, 1'b1, 1'b1, 64'h430, 64'h99);
        for (int s = 0; s < 3; s++) begin
            tick();
            checkOutput($sformatf("blk_gnt%0d", s), 64'(p_gnt), 64'h0);
            checkOutput($sformatf("blk_outst%0d", s), 64'(outst), 64'h4);
        end
        checkOutput("blk_dnreq", 64'(dn_req), 64'h0);
        dn_rvalid = 1'b1;
        dn_rdata  = 64'h11;
        tick();
        dn_rvalid = 1'b0;
        checkOutput("lim_valid", 64'(p_valid), 64'h1);
        checkOutput("lim_data",  p_rdata, 64'h11);
        checkOutput("lim_outst3", 64'(outst), 64'h3);
        checkOutput("lim_gnt_pop", 64'(p_gnt), 64'h0);
        tick();
        checkOutput("lim_rd2_gnt",  64'(p_gnt), 64'h4);
        checkOutput("lim_rd2_addr", dn_addr, 64'h420);
        checkOutput("lim_rd2_outst", 64'(outst), 64'h4);
        applyStimulus(2, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        checkOutput("lim_wr3_gnt",  64'(p_gnt), 64'h8);
        checkOutput("lim_wr3_we",   64'(dn_we), 64'h1);
        checkOutput("lim_wr3_outst", 64'(outst), 64'h4);
        applyStimulus(3, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        checkOutput("lim_idle", 64'(dn_req), 64'h0);
        expTag[0] = 4'h2;
        expTag[1] = 4'h1;
        expTag[2] = 4'h2;
        expTag[3] = 4'h4;
        for (int r = 0; r < 4; r++) begin
            expData   = 64'h21 + 64'(r);
            dn_rvalid = 1'b1;
            dn_rdata  = expData;
            tick();
            checkOutput($sformatf("drn_valid%0d", r), 64'(p_valid), 64'(expTag[r]));
            checkOutput($sformatf("drn_data%0d", r),  p_rdata, expData);
        end
        dn_rvalid = 1'b0;
        tick();
        checkOutput("drn_outst", 64'(outst), 64'h0);
        checkOutput("drn_valid_off", 64'(p_valid), 64'h0);

        // Responses return in issue order: port 3 then port 1
        $display("[TB] response ordering");
        applyStimulus(3, 1'b1, 1'b0, 64'h300, 64'h0);
        tick();
        checkOutput("ord_gnt3", 64'(p_gnt), 64'h8);
        applyStimulus(3, 1'b0, 1'b0, 64'h0, 64'h0);
        applyStimulus(1, 1'b1, 1'b0, 64'h310, 64'h0);
        tick();
        checkOutput("ord_gnt1", 64'(p_gnt), 64'h2);
        applyStimulus(1, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        checkOutput("ord_outst", 64'(outst), 64'h2);
        dn_rvalid = 1'b1;
        dn_rdata  = 64'hA;
        tick();
        checkOutput("ord_valid3", 64'(p_valid), 64'h8);
        checkOutput("ord_dataA",  p_rdata, 64'hA);
        dn_rdata = 64'hB;
        tick();
        dn_rvalid = 1'b0;
        checkOutput("ord_valid1", 64'(p_valid), 64'h2);
        checkOutput("ord_dataB",  p_rdata, 64'hB);
        tick();
        checkOutput("ord_outst0", 64'(outst), 64'h0);
        checkOutput("tot_gcnt", grant_count, 64'd15);

        // Orphan response sets the sticky error; reset clears it
        $display("[TB] orphan response");
        dn_rvalid = 1'b1;
        dn_rdata  = 64'h77;
        tick();
        dn_rvalid = 1'b0;
        checkOutput("orph_err",   64'(err), 64'h1);
        checkOutput("orph_valid", 64'(p_valid), 64'h0);
        checkOutput("orph_outst", 64'(outst), 64'h0);
        tick();
        tick();
        checkOutput("orph_sticky", 64'(err), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("orph_rst_err",  64'(err), 64'h0);
        checkOutput("orph_rst_gcnt", grant_count, 64'h0);
        tick();

        $display("test done: total=%0d bad=%0d", testCount, failCount);
        $finish;
    end

endmodule
